// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   RW_*            funct3 access-type encodings (byte/half/word, signed/unsigned)
//   lsu_state_e     controller state encoding
//   is_aligned()    natural-alignment check for an access size and the low address bits
//   access_bytes()  number of operand bytes for an access size
package lsu_pkg;

    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC_ALIGNED,
        ST_LD_LO,
        ST_LD_HI,
        ST_ST_BYTE,
        ST_RESP
    } lsu_state_e;

    // size is rwtyp[1:0]: 00 byte, 01 half, 1x word
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~addr_lo[0];
            default: return (addr_lo == 2'b00);
        endcase
    endfunction

    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: selects the operand from a 64-bit little-endian window
// and sign/zero-extends it to 32 bits.
//   window    in  64  {upper word, lower word} as read from memory
//   byte_off  in  2   byte offset of the operand inside the lower word
//   rwtyp     in  3   funct3 access type (bit 2 set = zero-extend)
//   rdata     out 32  extended load result
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  rwtyp,
    output logic [31:0] rdata
);

    logic [31:0] sel;

    always_comb begin
        sel = 32'(window >> {byte_off, 3'b000});
        case (rwtyp)
            RW_B:    rdata = {{24{sel[7]}}, sel[7:0]};
            RW_BU:   rdata = {24'h0, sel[7:0]};
            RW_H:    rdata = {{16{sel[15]}}, sel[15:0]};
            RW_HU:   rdata = {16'h0, sel[15:0]};
            default: rdata = sel;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit, initiator side of the data memory bus.
// Accepts one load/store at a time, splits misaligned accesses into legal
// bus sequences and returns extended load data or an error.
//   clk, rstn               clock, synchronous active-low reset
//   req_*                   valid/ready request from EX (wen, rwtyp, addr, wdata)
//   resp_*                  valid/ready response (rdata, err)
//   mem_bus_*               memory data port; rdata is combinational from addr/rwtyp
// Optional feature macro: MISALIGN_TRAP_EN -- when defined, any misaligned
// half/word access is answered with an error and no bus activity instead of
// being split.
//
// state          | meaning
// ---------------+--------------------------------------------------------
// ST_IDLE        | req_ready=1, waiting for a request
// ST_ACC_ALIGNED | single naturally aligned bus access
// ST_LD_LO       | misaligned load, lower aligned word read
// ST_LD_HI       | misaligned load, upper aligned word read
// ST_ST_BYTE     | misaligned store, one byte write per cycle (cnt_q = byte k)
// ST_RESP        | resp_valid=1 held until resp_ready
module lsu_bus_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_rwtyp,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_bus_wen,
    output logic [2:0]  mem_bus_rwtyp,
    output logic [31:0] mem_bus_addr,
    output logic [31:0] mem_bus_wdata,
    input  logic [31:0] mem_bus_rdata
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [2:0]  rwtyp_q, rwtyp_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        bus_wen_q, bus_wen_d;
    logic [2:0]  bus_rwtyp_q, bus_rwtyp_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        illegal, misaligned, in_range, trap;
    logic [31:0] span_start, span_off;
    logic [3:0]  span_len;
    logic [2:0]  last_k;
    logic [63:0] align_window;
    logic [1:0]  align_off;
    logic [31:0] align_rdata;

    // Request decode. A split load reads both full aligned words, so its range
    // check covers those 8 bytes rather than just the operand bytes; the bus
    // never addresses unbacked memory. Offsets are taken modulo 2^32, so a
    // wrapped span lands far outside the window and is rejected.
    always_comb begin
        illegal    = (req_rwtyp == 3'b011) || (req_rwtyp[2:1] == 2'b11)
                     || (req_wen && req_rwtyp[2]);
        misaligned = !is_aligned(req_rwtyp[1:0], req_addr[1:0]);
        if (misaligned && !req_wen) begin
            span_start = {req_addr[31:2], 2'b00};
            span_len   = 4'd8;
        end else begin
            span_start = req_addr;
            span_len   = {1'b0, access_bytes(req_rwtyp[1:0])};
        end
        span_off = span_start - MEM_BASE;
        in_range = (span_off < MEM_SIZE) && ((MEM_SIZE - span_off) >= {28'h0, span_len});
`ifdef MISALIGN_TRAP_EN
        trap = misaligned;
`else
        trap = 1'b0;
`endif
    end

    // Aligned loads reuse the aligner on the single returned word at offset 0
    // so the result is extended here regardless of what the memory returns
    // above the operand.
    always_comb begin
        if (state_q == ST_ACC_ALIGNED) begin
            align_window = {32'h0, mem_bus_rdata};
            align_off    = 2'b00;
        end else begin
            align_window = {mem_bus_rdata, lo_q};
            align_off    = addr_q[1:0];
        end
    end

    lsu_load_align u_align (
        .window   (align_window),
        .byte_off (align_off),
        .rwtyp    (rwtyp_q),
        .rdata    (align_rdata)
    );

    assign last_k = access_bytes(rwtyp_q[1:0]) - 3'd1;

    // Bus outputs are registered: the values computed here are those driven
    // during the next state, and default to 0 so the bus is idle elsewhere.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        rwtyp_d      = rwtyp_q;
        cnt_d        = cnt_q;
        wen_d        = wen_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        bus_wen_d    = 1'b0;
        bus_rwtyp_d  = 3'b000;
        bus_addr_d   = 32'h0;
        bus_wdata_d  = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rwtyp_d     = req_rwtyp;
                    wen_d       = req_wen;
                    cnt_d       = 3'd0;
                    req_ready_d = 1'b0;
                    if (illegal || !in_range || trap) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else if (!misaligned) begin
                        state_d     = ST_ACC_ALIGNED;
                        bus_wen_d   = req_wen;
                        bus_rwtyp_d = req_rwtyp;
                        bus_addr_d  = req_addr;
                        bus_wdata_d = req_wdata;
                    end else if (!req_wen) begin
                        state_d     = ST_LD_LO;
                        bus_rwtyp_d = RW_W;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                    end else begin
                        state_d     = ST_ST_BYTE;
                        bus_wen_d   = 1'b1;
                        bus_rwtyp_d = RW_B;
                        bus_addr_d  = req_addr;
                        bus_wdata_d = {24'h0, req_wdata[7:0]};
                    end
                end
            end

            ST_ACC_ALIGNED: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = wen_q ? 32'h0 : align_rdata;
            end

            ST_LD_LO: begin
                state_d     = ST_LD_HI;
                lo_d        = mem_bus_rdata;
                bus_rwtyp_d = RW_W;
                bus_addr_d  = bus_addr_q + 32'd4;
            end

            ST_LD_HI: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = align_rdata;
            end

            ST_ST_BYTE: begin
                if (cnt_q == last_k) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                end else begin
                    cnt_d       = cnt_q + 3'd1;
                    bus_wen_d   = 1'b1;
                    bus_rwtyp_d = RW_B;
                    bus_addr_d  = addr_q + {29'h0, cnt_d};
                    bus_wdata_d = {24'h0, wdata_q[{cnt_d[1:0], 3'b000} +: 8]};
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            lo_q         <= 32'h0;
            rwtyp_q      <= 3'b000;
            cnt_q        <= 3'd0;
            wen_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            bus_wen_q    <= 1'b0;
            bus_rwtyp_q  <= 3'b000;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            rwtyp_q      <= rwtyp_d;
            cnt_q        <= cnt_d;
            wen_q        <= wen_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            bus_wen_q    <= bus_wen_d;
            bus_rwtyp_q  <= bus_rwtyp_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_bus_wen   = bus_wen_q;
    assign mem_bus_rwtyp = bus_rwtyp_q;
    assign mem_bus_addr  = bus_addr_q;
    assign mem_bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed testbench for lsu_bus_master with a byte-array memory model.
// Split-access scenarios are compiled for the default build; the trap
// scenario is compiled when MISALIGN_TRAP_EN is defined.
module tb_lsu_bus_master;
    import lsu_pkg::*;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SIZE = 32'h0002_0000;

    logic        clk;
    logic        rstn;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_rwtyp;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_bus_wen;
    logic [2:0]  mem_bus_rwtyp;
    logic [31:0] mem_bus_addr, mem_bus_wdata, mem_bus_rdata;

    int checks = 0;
    int errors = 0;
    int bus_cycles = 0;
    int wen_cycles = 0;
    logic [31:0] wlog_addr[$];
    logic [7:0]  wlog_data[$];
    logic [7:0]  mem [0:131071];

    lsu_bus_master #(.MEM_BASE(BASE), .MEM_SIZE(SIZE)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_rwtyp(req_rwtyp), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_bus_wen(mem_bus_wen), .mem_bus_rwtyp(mem_bus_rwtyp),
        .mem_bus_addr(mem_bus_addr), .mem_bus_wdata(mem_bus_wdata),
        .mem_bus_rdata(mem_bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        if (off < SIZE) return mem[off[16:0]];
        return 8'h00;
    endfunction

    // Memory returns the operand LSB-aligned and extended per rwtyp.
    always_comb begin
        logic [31:0] w;
        w = {rd_byte(mem_bus_addr + 32'd3), rd_byte(mem_bus_addr + 32'd2),
             rd_byte(mem_bus_addr + 32'd1), rd_byte(mem_bus_addr)};
        case (mem_bus_rwtyp)
            3'b000:  mem_bus_rdata = {{24{w[7]}}, w[7:0]};
            3'b100:  mem_bus_rdata = {24'h0, w[7:0]};
            3'b001:  mem_bus_rdata = {{16{w[15]}}, w[15:0]};
            3'b101:  mem_bus_rdata = {16'h0, w[15:0]};
            default: mem_bus_rdata = w;
        endcase
    end

    always @(posedge clk) begin
        int n;
        logic [31:0] off;
        if (mem_bus_wen || mem_bus_addr != 32'h0 || mem_bus_rwtyp != 3'b000 || mem_bus_wdata != 32'h0)
            bus_cycles++;
        if (mem_bus_wen) begin
            wen_cycles++;
            n = (mem_bus_rwtyp == 3'b000) ? 1 : (mem_bus_rwtyp == 3'b001) ? 2 : 4;
            for (int i = 0; i < n; i++) begin
                off = mem_bus_addr + i - BASE;
                if (off < SIZE) mem[off[16:0]] = mem_bus_wdata[8*i +: 8];
                wlog_addr.push_back(mem_bus_addr + i);
                wlog_data.push_back(mem_bus_wdata[8*i +: 8]);
            end
        end
    end

    task automatic preload_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] off;
            off = a + i - BASE;
            mem[off[16:0]] = w[8*i +: 8];
        end
    endtask

    // Issues one request with resp_ready=1 and returns after the response is consumed.
    task automatic do_req(input logic wen, input logic [2:0] rw, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        bus_cycles = 0;
        wen_cycles = 0;
        wlog_addr.delete();
        wlog_data.delete();
        req_valid = 1'b1; req_wen = wen; req_rwtyp = rw; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = 1'b0; req_rwtyp = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (resp_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL resp_timeout addr=%h: no resp_valid after %0d cycles", a, lat);
        end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
        checks++; if ({mem_bus_wen, mem_bus_rwtyp, mem_bus_addr, mem_bus_wdata} !== 68'h0) begin
            errors++; $display("FAIL reset_bus got wen=%b rw=%b addr=%h wd=%h exp all 0",
                               mem_bus_wen, mem_bus_rwtyp, mem_bus_addr, mem_bus_wdata);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_aligned_load();
        logic [31:0] rd; logic er; int lat;
        preload_word(BASE + 32'h10, 32'hDEAD_BEEF);
        do_req(1'b0, RW_W, BASE + 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got=%h exp=deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err got=%b exp=0", er); end
        checks++; if (lat != 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        checks++; if (bus_cycles != 1) begin errors++; $display("FAIL lw_bus_cycles got=%0d exp=1", bus_cycles); end
        checks++; if (wen_cycles != 0) begin errors++; $display("FAIL lw_wen_cycles got=%0d exp=0", wen_cycles); end
    endtask

    task automatic test_narrow_loads();
        logic [2:0]  rw_t  [5] = '{RW_B, RW_BU, RW_H, RW_HU, RW_B};
        logic [31:0] off_t [5] = '{32'h23, 32'h23, 32'h22, 32'h22, 32'h20};
        logic [31:0] exp_t [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8012,
                                   32'h0000_8012, 32'h0000_0056};
        logic [31:0] rd; logic er; int lat;
        preload_word(BASE + 32'h20, 32'h8012_3456);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, rw_t[i], BASE + off_t[i], 32'h0, rd, er, lat);
            checks++; if (rd !== exp_t[i] || er !== 1'b0) begin
                errors++; $display("FAIL narrow_load[%0d] got rdata=%h err=%b exp rdata=%h err=0", i, rd, er, exp_t[i]);
            end
            checks++; if (lat != 2 || bus_cycles != 1) begin
                errors++; $display("FAIL narrow_load_timing[%0d] got lat=%0d bus=%0d exp lat=2 bus=1", i, lat, bus_cycles);
            end
        end
    endtask

`ifndef MISALIGN_TRAP_EN
    task automatic test_misaligned_load();
        logic [2:0]  rw_t  [6] = '{RW_W, RW_H, RW_H, RW_H, RW_HU, RW_W};
        logic [31:0] off_t [6] = '{32'h06, 32'h05, 32'h07, 32'h0B, 32'h0B, 32'h09};
        logic [31:0] exp_t [6] = '{32'h6655_4433, 32'h0000_3322, 32'h0000_5544,
                                   32'hFFFF_F188, 32'h0000_F188, 32'hF188_7766};
        logic [31:0] rd; logic er; int lat;
        preload_word(BASE + 32'h04, 32'h4433_2211);
        preload_word(BASE + 32'h08, 32'h8877_6655);
        preload_word(BASE + 32'h0C, 32'h0000_00F1);
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, rw_t[i], BASE + off_t[i], 32'h0, rd, er, lat);
            checks++; if (rd !== exp_t[i] || er !== 1'b0) begin
                errors++; $display("FAIL split_load[%0d] got rdata=%h err=%b exp rdata=%h err=0", i, rd, er, exp_t[i]);
            end
            checks++; if (lat != 3 || bus_cycles != 2 || wen_cycles != 0) begin
                errors++; $display("FAIL split_load_timing[%0d] got lat=%0d bus=%0d wen=%0d exp 3/2/0",
                                   i, lat, bus_cycles, wen_cycles);
            end
        end
    endtask

    task automatic test_misaligned_store();
        logic [7:0] exp_b [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, RW_W, BASE + 32'h101, 32'hAABB_CCDD, rd, er, lat);
        checks++; if (lat != 5 || wen_cycles != 4 || er !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL sw_split got lat=%0d wen=%0d err=%b rdata=%h exp 5/4/0/0", lat, wen_cycles, er, rd);
        end
        checks++; if (wlog_addr.size() != 4) begin
            errors++; $display("FAIL sw_split_writes got=%0d exp=4", wlog_addr.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (wlog_addr[k] !== BASE + 32'h101 + k || wlog_data[k] !== exp_b[k]) begin
                    errors++; $display("FAIL sw_split_byte[%0d] got addr=%h data=%h exp addr=%h data=%h",
                                       k, wlog_addr[k], wlog_data[k], BASE + 32'h101 + k, exp_b[k]);
                end
            end
        end
        do_req(1'b0, RW_W, BASE + 32'h101, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hAABB_CCDD) begin errors++; $display("FAIL sw_split_readback got=%h exp=aabbccdd", rd); end

        preload_word(BASE + 32'h200, 32'hEEEE_EEEE);
        do_req(1'b1, RW_H, BASE + 32'h201, 32'hFFFF_1234, rd, er, lat);
        checks++; if (lat != 3 || wen_cycles != 2) begin
            errors++; $display("FAIL sh_split got lat=%0d wen=%0d exp 3/2", lat, wen_cycles);
        end
        checks++; if ({rd_byte(BASE + 32'h203), rd_byte(BASE + 32'h202), rd_byte(BASE + 32'h201), rd_byte(BASE + 32'h200)} !== 32'hEE12_34EE) begin
            errors++; $display("FAIL sh_split_mem got=%h exp=ee1234ee",
                               {rd_byte(BASE + 32'h203), rd_byte(BASE + 32'h202), rd_byte(BASE + 32'h201), rd_byte(BASE + 32'h200)});
        end
    endtask

    task automatic test_reset_mid();
        preload_word(BASE + 32'h400, 32'hEEEE_EEEE);
        preload_word(BASE + 32'h404, 32'hEEEE_EEEE);
        wen_cycles = 0;
        req_valid = 1'b1; req_wen = 1'b1; req_rwtyp = RW_W; req_addr = BASE + 32'h401; req_wdata = 32'h1122_3344;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_bus_wen !== 1'b0 || mem_bus_addr !== 32'h0) begin
            errors++; $display("FAIL midreset_state got ready=%b rvalid=%b wen=%b addr=%h exp 1/0/0/0",
                               req_ready, resp_valid, mem_bus_wen, mem_bus_addr);
        end
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0 || wen_cycles != 2) begin
            errors++; $display("FAIL midreset_after got rvalid=%b wen=%0d exp 0/2", resp_valid, wen_cycles);
        end
        checks++; if ({rd_byte(BASE + 32'h404), rd_byte(BASE + 32'h403), rd_byte(BASE + 32'h402), rd_byte(BASE + 32'h401)} !== 32'hEEEE_3344) begin
            errors++; $display("FAIL midreset_mem got=%h exp=eeee3344",
                               {rd_byte(BASE + 32'h404), rd_byte(BASE + 32'h403), rd_byte(BASE + 32'h402), rd_byte(BASE + 32'h401)});
        end
    endtask
`else
    task automatic test_trap();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, RW_H, BASE + 32'h3, 32'h1234, rd, er, lat);
        checks++; if (er !== 1'b1 || lat != 1 || bus_cycles != 0) begin
            errors++; $display("FAIL trap_sh got err=%b lat=%0d bus=%0d exp 1/1/0", er, lat, bus_cycles);
        end
        do_req(1'b0, RW_W, BASE + 32'h6, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || bus_cycles != 0) begin
            errors++; $display("FAIL trap_lw got err=%b rdata=%h lat=%0d bus=%0d exp 1/0/1/0", er, rd, lat, bus_cycles);
        end
    endtask
`endif

    task automatic test_aligned_store();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, RW_W, BASE + 32'h300, 32'h0BAD_F00D, rd, er, lat);
        checks++; if (lat != 2 || wen_cycles != 1 || er !== 1'b0) begin
            errors++; $display("FAIL sw_aligned got lat=%0d wen=%0d err=%b exp 2/1/0", lat, wen_cycles, er);
        end
        do_req(1'b1, RW_B, BASE + 32'h305, 32'h1234_56A5, rd, er, lat);
        do_req(1'b0, RW_BU, BASE + 32'h305, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0000_00A5) begin errors++; $display("FAIL sb_readback got=%h exp=000000a5", rd); end
        do_req(1'b0, RW_W, BASE + 32'h300, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL sw_readback got=%h exp=0badf00d", rd); end
    endtask

    task automatic test_errors();
        logic        wen_t [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  rw_t  [8] = '{RW_H, 3'b011, RW_BU, 3'b110, 3'b111, RW_W, RW_H, RW_W};
        logic [31:0] a_t   [8] = '{32'h7FFF_FFFE, 32'h8000_0010, 32'h8000_0010, 32'h8000_0010,
                                   32'h8000_0010, 32'h8002_0000, 32'h8001_FFFF, 32'hFFFF_FFFE};
        logic [31:0] rd; logic er; int lat;
        for (int i = 0; i < 8; i++) begin
            do_req(wen_t[i], rw_t[i], a_t[i], 32'hFFFF_FFFF, rd, er, lat);
            checks++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || bus_cycles != 0 || wen_cycles != 0) begin
                errors++; $display("FAIL err_case[%0d] got err=%b rdata=%h lat=%0d bus=%0d wen=%0d exp 1/0/1/0/0",
                                   i, er, rd, lat, bus_cycles, wen_cycles);
            end
        end
        preload_word(BASE + 32'h1_FFFC, 32'h1357_9BDF);
        do_req(1'b0, RW_W, BASE + 32'h1_FFFC, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h1357_9BDF || lat != 2) begin
            errors++; $display("FAIL last_word got err=%b rdata=%h lat=%0d exp 0/13579bdf/2", er, rd, lat);
        end
    endtask

    task automatic test_resp_stall();
        int lat;
        preload_word(BASE + 32'h10, 32'hDEAD_BEEF);
        for (int s = 0; s < 2; s++) begin
            bus_cycles = 0;
            resp_ready = 1'b0;
            req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE + 32'h10;
            req_rwtyp = (s == 0) ? 3'b011 : RW_W;
            @(posedge clk); #1;
            req_valid = 1'b0; req_rwtyp = 3'b000; req_addr = 32'h0;
            lat = 1;
            while (resp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
            for (int c = 0; c < 5; c++) begin
                checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_err !== (s == 0) ||
                              resp_rdata !== ((s == 0) ? 32'h0 : 32'hDEAD_BEEF)) begin
                    errors++; $display("FAIL stall[%0d] cyc%0d got rvalid=%b ready=%b err=%b rdata=%h",
                                       s, c, resp_valid, req_ready, resp_err, resp_rdata);
                end
                @(posedge clk); #1;
            end
            checks++; if (bus_cycles != s) begin
                errors++; $display("FAIL stall_bus[%0d] got=%0d exp=%0d", s, bus_cycles, s);
            end
            resp_ready = 1'b1;
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL stall_release[%0d] got rvalid=%b ready=%b exp 0/1", s, resp_valid, req_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        preload_word(BASE + 32'h40, 32'h0102_0304);
        preload_word(BASE + 32'h44, 32'hA0B0_C0D0);
        do_req(1'b0, RW_W, BASE + 32'h40, 32'h0, rd, er, lat);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got ready=%b rvalid=%b exp 1/0", req_ready, resp_valid);
        end
        checks++; if (rd !== 32'h0102_0304) begin errors++; $display("FAIL b2b_first got=%h exp=01020304", rd); end
        do_req(1'b0, RW_HU, BASE + 32'h46, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0000_A0B0 || lat != 2) begin
            errors++; $display("FAIL b2b_second got rdata=%h lat=%0d exp 0000a0b0/2", rd, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
        rstn = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_rwtyp = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        test_reset();
        test_aligned_load();
        test_narrow_loads();
`ifndef MISALIGN_TRAP_EN
        test_misaligned_load();
        test_misaligned_store();
`else
        test_trap();
`endif
        test_aligned_store();
        test_errors();
        test_resp_stall();
        test_back_to_back();
`ifndef MISALIGN_TRAP_EN
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
